// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Collects a stream of bytes into 32-bit words. Four accepted bytes form
//   one word. The word is presented on a valid/ready output port. While a
//   completed word waits on the output, the next word can still collect its
//   first three bytes.
//
// Parameters
//   BIG_ENDIAN : 0 -> the first byte of a group lands in m_data[7:0]
//                1 -> the first byte of a group lands in m_data[31:24]
//
// Ports
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   clr      in   1  synchronous discard of the partially assembled word
//   s_data   in   8  incoming byte
//   s_valid  in   1  s_data is valid
//   s_ready  out  1  a byte can be accepted this cycle
//   m_data   out 32  assembled word
//   m_valid  out  1  m_data holds a complete word
//   m_ready  in   1  consumer takes m_data this cycle
//   byte_cnt out  2  bytes currently held in the partial word (0-3)

module byte_word_packer #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [1:0]  byte_cnt
);

  logic [31:0] partial;
  logic [31:0] merged;
  logic [1:0]  lane;
  logic        s_beat;
  logic        m_beat;
  logic        word_done;

  // Only the 4th byte needs the output register to be free. Bytes 1-3
  // go into the partial register, so they are always accepted. clr removes
  // a coincident byte from the beat. s_ready itself stays independent of clr.
  always_comb begin
    s_ready   = !((byte_cnt == 2'd3) && m_valid && !m_ready);
    s_beat    = s_valid && s_ready && !clr;
    m_beat    = m_valid && m_ready;
    word_done = s_beat && (byte_cnt == 2'd3);
    lane      = BIG_ENDIAN ? (2'd3 - byte_cnt) : byte_cnt;
    // The merged value includes the incoming byte. On the 4th byte this is
    // the complete word, which goes straight to the output register.
    merged    = partial;
    merged[{lane, 3'b000} +: 8] = s_data;
  end

  // Partial word and fill count. Lanes that were not written are don't-care.
  // A new group overwrites every lane before the group is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial  <= 32'h0000_0000;
      byte_cnt <= 2'd0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
    end else if (s_beat) begin
      partial  <= merged;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Output register. A load has priority over a handoff, so when a new word
  // completes on the same cycle the old word is taken, m_valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= 32'h0000_0000;
      m_valid <= 1'b0;
    end else if (word_done) begin
      m_data  <= merged;
      m_valid <= 1'b1;
    end else if (m_beat) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
`timescale 1ns/1ps
// Testbench for byte_word_packer.
// Two instances (little- and big-endian) share all inputs, so both see the
// same handshake timing. A monitor process pops the expected words from
// per-instance queues on every output handoff.

module tb_byte_word_packer;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        m_ready;
  logic        s_ready,  s_ready_be;
  logic [31:0] m_data,   m_data_be;
  logic        m_valid,  m_valid_be;
  logic [1:0]  byte_cnt, byte_cnt_be;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_le[$];
  logic [31:0] exp_be[$];

  logic        random_en = 1'b0;
  logic        stall_le  = 1'b0;
  logic        stall_be  = 1'b0;
  logic [31:0] held_le, held_be;

  byte_word_packer #(.BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .byte_cnt(byte_cnt)
  );

  byte_word_packer #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_be),
    .m_data(m_data_be), .m_valid(m_valid_be), .m_ready(m_ready),
    .byte_cnt(byte_cnt_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Offer one byte and wait (bounded) until it has been accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited  = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout byte=%h s_ready=%b expected s_ready=1", b, s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pushWord(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    exp_le.push_back({b3, b2, b1, b0});
    exp_be.push_back({b0, b1, b2, b3});
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a handoff happens at the next rising edge whenever valid and
  // ready are both high at the falling edge. A held word must not change.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_le) begin
        checkOutput("stall_valid_le", {31'd0, m_valid}, 32'd1);
        checkOutput("stall_data_le", m_data, held_le);
      end
      if (stall_be) checkOutput("stall_data_be", m_data_be, held_be);
      if (m_valid && m_ready) begin
        if (exp_le.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word_le actual=%h expected none", m_data);
        end else checkOutput("word_le", m_data, exp_le.pop_front());
      end
      if (m_valid_be && m_ready) begin
        if (exp_be.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word_be actual=%h expected none", m_data_be);
        end else checkOutput("word_be", m_data_be, exp_be.pop_front());
      end
      stall_le = m_valid && !m_ready;
      stall_be = m_valid_be && !m_ready;
      held_le  = m_data;
      held_be  = m_data_be;
    end else begin
      stall_le = 1'b0;
      stall_be = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    stall_le = 1'b0;
    stall_be = 1'b0;
  end

  // Random output throttling, active only during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (random_en) m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [7:0] grp[4];
    int drain;

    rst_n = 1'b0; clr = 1'b0; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1;

    // Reset values
    #12;
    checkOutput("rst_byte_cnt", {30'd0, byte_cnt}, 32'd0);
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_data", m_data, 32'h0);
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("rst_s_ready_be", {31'd0, s_ready_be}, 32'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    waitCycles(1);

    // Basic packing, both byte orders, one-cycle latency and one-cycle valid
    $display("[TB] basic packing");
    pushWord(8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    checkOutput("latency_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("latency_data_le", m_data, 32'h44332211);
    checkOutput("latency_data_be", m_data_be, 32'h11223344);
    waitCycles(1);
    checkOutput("one_cycle_valid", {31'd0, m_valid}, 32'd0);

    // Output stall: bytes 5-7 accepted, byte 8 held back until the handoff
    $display("[TB] output stall");
    m_ready = 1'b0;
    pushWord(8'h01, 8'h02, 8'h03, 8'h04);
    pushWord(8'h05, 8'h06, 8'h07, 8'h08);
    for (int i = 1; i <= 7; i++) applyStimulus(8'(i));
    checkOutput("stall_byte_cnt", {30'd0, byte_cnt}, 32'd3);
    checkOutput("stall_word", m_data, 32'h04030201);
    s_data = 8'h08; s_valid = 1'b1;
    @(negedge clk);
    checkOutput("stall_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("handoff_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b0;
    checkOutput("no_bubble_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("no_bubble_data", m_data, 32'h08070605);
    checkOutput("no_bubble_cnt", {30'd0, byte_cnt}, 32'd0);
    waitCycles(2);
    m_ready = 1'b1;
    waitCycles(2);

    // clr drops the partial word and the coincident byte
    $display("[TB] clear");
    pushWord(8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    clr = 1'b1; s_data = 8'hCC; s_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; s_valid = 1'b0;
    checkOutput("clr_byte_cnt", {30'd0, byte_cnt}, 32'd0);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    waitCycles(3);

    // Asynchronous reset mid-cycle: with a partial word and with a pending word
    $display("[TB] async reset");
    applyStimulus(8'h9A);
    applyStimulus(8'h9B);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst1_byte_cnt", {30'd0, byte_cnt}, 32'd0);
    checkOutput("arst1_s_ready", {31'd0, s_ready}, 32'd1);
    rst_n = 1'b1;
    m_ready = 1'b0;
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    applyStimulus(8'hBE);
    applyStimulus(8'hEF);
    checkOutput("pre_arst2_valid", {31'd0, m_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst2_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("arst2_m_data", m_data, 32'h0);
    checkOutput("arst2_m_data_be", m_data_be, 32'h0);
    checkOutput("arst2_s_ready", {31'd0, s_ready}, 32'd1);
    rst_n = 1'b1;
    m_ready = 1'b1;
    pushWord(8'h55, 8'h66, 8'h77, 8'h88);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    waitCycles(3);

    // Random throttling against the byte-group model
    $display("[TB] random throttling");
    random_en = 1'b1;
    for (int g = 0; g < 250; g++) begin
      for (int k = 0; k < 4; k++) grp[k] = 8'($urandom_range(0, 255));
      pushWord(grp[0], grp[1], grp[2], grp[3]);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) waitCycles($urandom_range(1, 2));
        applyStimulus(grp[k]);
      end
    end
    random_en = 1'b0;
    m_ready = 1'b1;
    drain = 0;
    while ((exp_le.size() != 0 || exp_be.size() != 0) && drain < 50) begin
      waitCycles(1);
      drain++;
    end
    waitCycles(2);
    checkOutput("queue_empty_le", 32'(exp_le.size()), 32'd0);
    checkOutput("queue_empty_be", 32'(exp_be.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
